snn_spike_scoreboard: RTL and testbench

Synthesizable scoreboard that scores the spike output vector of the SNN against expected labels on-chip, replacing the bench-only match counting done at simulation end.
- Parametrised in output channel count and alignment latency.
- Adds pass/fail flagging, saturation handling and a sequential integer-percentage accuracy calculation.
- Sits beside the trained network in the testing top level and observes its outputs alongside the label stream.

---
 rtl/snn_spike_scoreboard.sv | 253 +++++++++++++++++++++++++
 tb/tb_snn_spike_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_spike_scoreboard.sv
// ---------------------------------------------------------------------------
// snn_spike_scoreboard
//   On-chip scorer for the SNN spike output vector. Expected vectors enter a
//   LAT-deep delay line and are compared with the network output LAT cycles
//   later. The block counts matches and scored samples, flags mismatches,
//   saturates both counters together, and computes an integer accuracy
//   percentage with a sequential restoring divider.
//
//   Optional feature macro: SNN_SB_SKIP_ZERO_EN
//     defined   -> all-zero expected vectors are not scored (they still
//                  carry the last marker through the delay line)
//     undefined -> all-zero expected vectors are scored like any other
// ---------------------------------------------------------------------------
module snn_spike_scoreboard #(
    parameter int N_OUT = 3,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [N_OUT-1:0] exp_vec,
    input  logic             exp_last,
    input  logic [N_OUT-1:0] dut_vec,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] scored_count,
    output logic [6:0]       accuracy_pct,
    output logic             mismatch,
    output logic             overflow
);

    // Dividend is 100*match_count, which needs 7 more bits than the counter.
    localparam int               DIV_W   = CNT_W + 7;
    localparam int               STEP_W  = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [6:0]       PCT_MAX = 7'd100;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Delay line: index 0 is the tail (newest), LAT-1 is the head (oldest).
    logic [LAT-1:0]   dl_valid_q, dl_valid_d;
    logic [LAT-1:0]   dl_last_q,  dl_last_d;
    logic [N_OUT-1:0] dl_vec_q [LAT];
    logic [N_OUT-1:0] dl_vec_d [LAT];

    logic [CNT_W-1:0] match_q,  match_d;
    logic [CNT_W-1:0] scored_q, scored_d;
    logic [6:0]       acc_q,    acc_d;
    logic             mism_q,   mism_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;

    // Restoring divider: dvd shifts the dividend out at the top and the
    // quotient in at the bottom; rem is the partial remainder.
    logic [DIV_W-1:0]  dvd_q,  dvd_d;
    logic [CNT_W-1:0]  rem_q,  rem_d;
    logic [CNT_W-1:0]  dsr_q,  dsr_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic             start_go;
    logic             accept;
    logic             head_live;
    logic             head_scored;
    logic             head_match;
    logic [N_OUT-1:0] head_vec;
    logic             head_last;

    logic [CNT_W:0]   rem_sh;
    logic             div_ge;
    logic [CNT_W-1:0] rem_nx;
    logic [DIV_W-1:0] dvd_nx;
    logic [6:0]       quo_pct;

    assign start_go   = start && (state_q == IDLE || state_q == DONE);
    assign accept     = (state_q == RUN) && exp_valid;
    assign head_vec   = dl_vec_q[LAT-1];
    assign head_last  = dl_last_q[LAT-1];
    assign head_live  = dl_valid_q[LAT-1] && (state_q == RUN || state_q == DRAIN);
    assign head_match = (dut_vec == head_vec);

`ifdef SNN_SB_SKIP_ZERO_EN
    assign head_scored = head_live && (|head_vec);
`else
    assign head_scored = head_live;
`endif

    // Shift the delay line; only RUN injects valid entries, start flushes it.
    always_comb begin
        dl_valid_d[0] = accept;
        dl_last_d[0]  = exp_last;
        dl_vec_d[0]   = exp_vec;
        for (int i = 1; i < LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_last_d[i]  = dl_last_q[i-1];
            dl_vec_d[i]   = dl_vec_q[i-1];
        end
        if (start_go) begin
            dl_valid_d = '0;
        end
    end

    // One restoring-division step and the clamped final quotient.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[DIV_W-1]};
        div_ge  = (rem_sh >= {1'b0, dsr_q});
        rem_nx  = div_ge ? CNT_W'(rem_sh - {1'b0, dsr_q}) : rem_sh[CNT_W-1:0];
        dvd_nx  = {dvd_q[DIV_W-2:0], div_ge};
        quo_pct = (dvd_nx > DIV_W'(PCT_MAX)) ? PCT_MAX : dvd_nx[6:0];
    end

    // Next-state, head scoring and divider control.
    always_comb begin
        // NOTE: every signal gets a default here so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        match_d  = match_q;
        scored_d = scored_q;
        acc_d    = acc_q;
        mism_d   = 1'b0;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        step_d   = step_q;

        // Score the head entry. Once either counter has saturated both
        // freeze so the match/scored ratio stays meaningful.
        if (head_scored) begin
            mism_d = !head_match;
            if (!ovf_q) begin
                if (scored_q == CNT_MAX || (head_match && match_q == CNT_MAX)) begin
                    ovf_d = 1'b1;
                end else begin
                    scored_d = scored_q + 1'b1;
                    if (head_match) begin
                        match_d = match_q + 1'b1;
                    end
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    match_d  = '0;
                    scored_d = '0;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                if (exp_valid && exp_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last entry is scored on this same edge, so the divider
                // is loaded from the updated counter values.
                if (head_live && head_last) begin
                    state_d = CALC;
                    dvd_d   = DIV_W'(match_d) * DIV_W'(PCT_MAX);
                    rem_d   = '0;
                    dsr_d   = scored_d;
                    step_d  = '0;
                end
            end
            CALC: begin
                if (dsr_q == '0) begin
                    state_d = DONE;
                    acc_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    dvd_d  = dvd_nx;
                    rem_d  = rem_nx;
                    step_d = step_q + 1'b1;
                    if (step_q == STEP_W'(DIV_W - 1)) begin
                        state_d = DONE;
                        acc_d   = quo_pct;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            dl_valid_q <= '0;
            match_q    <= '0;
            scored_q   <= '0;
            acc_q      <= '0;
            mism_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            dl_valid_q <= dl_valid_d;
            match_q    <= match_d;
            scored_q   <= scored_d;
            acc_q      <= acc_d;
            mism_q     <= mism_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dsr_q      <= dsr_d;
            step_q     <= step_d;
        end
    end

    // Delay-line payload; always qualified by the reset valid bits.
    always_ff @(posedge clock) begin
        // NOTE: the payload storage is left unreset; nothing reads it unless
        // its valid bit is set, and the valid bits are reset.
        dl_last_q <= dl_last_d;
        for (int i = 0; i < LAT; i++) begin
            dl_vec_q[i] <= dl_vec_d[i];
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN) || (state_q == CALC);
    assign done         = done_q;
    assign match_count  = match_q;
    assign scored_count = scored_q;
    assign accuracy_pct = acc_q;
    assign mismatch     = mism_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_snn_spike_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_snn_spike_scoreboard
//   Three scoreboard instances (default, LAT=4/N_OUT=8, CNT_W=4) share one
//   stimulus bus; sel routes start/exp_valid to one of them. A bench-side
//   pipeline reproduces the network output from the expected stream with
//   selectable corruption. Expected per-sample outcomes and per-run results
//   are queued when stimulus is driven and popped when the DUT reports them.
// ---------------------------------------------------------------------------
module tb_snn_spike_scoreboard;

    typedef struct {
        int match;
        int scored;
        int acc;
        int ovf;
    } result_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       exp_valid;
    logic       exp_last;
    logic [7:0] exp_vec8;
    logic       corrupt;
    int         sel;

    logic [7:0] pipe [4];

    always #5 clock = ~clock;

    // Network-output model: expected vector delayed, optionally corrupted.
    always @(posedge clock) begin
        pipe[0] <= exp_vec8 ^ {7'b0, corrupt};
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    logic start_a, start_b, start_c, ev_a, ev_b, ev_c;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign ev_a    = exp_valid && (sel == 0);
    assign ev_b    = exp_valid && (sel == 1);
    assign ev_c    = exp_valid && (sel == 2);

    logic        busy_a, done_a, mism_a, ovf_a;
    logic [15:0] match_a, scored_a;
    logic [6:0]  acc_a;
    logic        busy_b, done_b, mism_b, ovf_b;
    logic [15:0] match_b, scored_b;
    logic [6:0]  acc_b;
    logic        busy_c, done_c, mism_c, ovf_c;
    logic [3:0]  match_c, scored_c;
    logic [6:0]  acc_c;

    snn_spike_scoreboard #(.N_OUT(3), .LAT(2), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .exp_valid(ev_a),
        .exp_vec(exp_vec8[2:0]), .exp_last(exp_last), .dut_vec(pipe[1][2:0]),
        .busy(busy_a), .done(done_a), .match_count(match_a), .scored_count(scored_a),
        .accuracy_pct(acc_a), .mismatch(mism_a), .overflow(ovf_a)
    );

    snn_spike_scoreboard #(.N_OUT(8), .LAT(4), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .exp_valid(ev_b),
        .exp_vec(exp_vec8), .exp_last(exp_last), .dut_vec(pipe[3]),
        .busy(busy_b), .done(done_b), .match_count(match_b), .scored_count(scored_b),
        .accuracy_pct(acc_b), .mismatch(mism_b), .overflow(ovf_b)
    );

    snn_spike_scoreboard #(.N_OUT(3), .LAT(2), .CNT_W(4)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .exp_valid(ev_c),
        .exp_vec(exp_vec8[2:0]), .exp_last(exp_last), .dut_vec(pipe[1][2:0]),
        .busy(busy_c), .done(done_c), .match_count(match_c), .scored_count(scored_c),
        .accuracy_pct(acc_c), .mismatch(mism_c), .overflow(ovf_c)
    );

    logic        obs_busy, obs_done, obs_mism, obs_ovf;
    logic [15:0] obs_match, obs_scored;
    logic [6:0]  obs_acc;

    always_comb begin
        case (sel)
            0: begin
                obs_busy = busy_a; obs_done = done_a; obs_mism = mism_a; obs_ovf = ovf_a;
                obs_match = match_a; obs_scored = scored_a; obs_acc = acc_a;
            end
            1: begin
                obs_busy = busy_b; obs_done = done_b; obs_mism = mism_b; obs_ovf = ovf_b;
                obs_match = match_b; obs_scored = scored_b; obs_acc = acc_b;
            end
            default: begin
                obs_busy = busy_c; obs_done = done_c; obs_mism = mism_c; obs_ovf = ovf_c;
                obs_match = {12'b0, match_c}; obs_scored = {12'b0, scored_c}; obs_acc = acc_c;
            end
        endcase
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input int got, input int want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Scoreboard state.
    bit      wrong_q [$];
    result_t res_q [$];
    bit      mon_en = 1'b0;
    int      m_scored, m_match, prev_scored, mism_pulses;
    bit      mon_w, mon_exp;

    // Per-sample monitor, sampled 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            mon_exp = 1'b0;
            if (int'(obs_scored) != prev_scored) begin
                check("sb_pending", int'(wrong_q.size() > 0), 1);
                if (wrong_q.size() > 0) begin
                    mon_w = wrong_q.pop_front();
                    m_scored++;
                    if (!mon_w) m_match++;
                    mon_exp = mon_w;
                    check("scored_live", obs_scored, m_scored);
                    check("match_live", obs_match, m_match);
                end
            end
            check("mismatch", obs_mism, mon_exp);
            if (obs_mism) mism_pulses++;
            prev_scored = obs_scored;
        end
    end

    task automatic do_run(input int inst, input int n, input logic [31:0] wmask,
                          input bit zero_vecs, input bit overlap, input bit start_in_calc,
                          input int exp_match, input int exp_scored, input int exp_acc,
                          input int exp_ovf, input bit use_mon);
        int         lat, cw, calc, k, max_v;
        bit         seen;
        logic [7:0] v, prev;
        result_t    r;
        lat   = (inst == 1) ? 4 : 2;
        cw    = (inst == 2) ? 4 : 16;
        max_v = (inst == 1) ? 255 : 7;
        calc  = (exp_scored == 0) ? 1 : cw + 7;
        sel   = inst;
        r.match = exp_match; r.scored = exp_scored; r.acc = exp_acc; r.ovf = exp_ovf;
        res_q.push_back(r);
        wrong_q.delete();
        m_scored = 0; m_match = 0; prev_scored = 0; mism_pulses = 0;
        mon_en = use_mon;

        start = 1'b1; exp_valid = overlap; exp_last = overlap; exp_vec8 = 8'h05; corrupt = 1'b1;
        @(negedge clock);
        start = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        check("busy_after_start", obs_busy, 1);
        check("scored_clear", obs_scored, 0);
        check("acc_clear", obs_acc, 0);
        check("ovf_clear", obs_ovf, 0);

        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                exp_valid = 1'b0; exp_last = 1'b1;
                @(negedge clock);
            end
            if (zero_vecs) v = 8'h00;
            else begin
                do v = 8'($urandom_range(1, max_v)); while (v == prev);
            end
            prev = v;
            exp_vec8 = v; exp_valid = 1'b1; exp_last = (i == n - 1); corrupt = wmask[i];
            wrong_q.push_back(wmask[i]);
            @(negedge clock);
        end

        // An extra valid last sample in DRAIN must be ignored.
        exp_valid = 1'b1; exp_last = 1'b1; exp_vec8 = 8'h01; corrupt = 1'b0;
        k = 0; seen = 1'b0;
        while (k < lat + calc + 20 && !seen) begin
            @(negedge clock);
            k++;
            exp_valid = 1'b0; exp_last = 1'b0;
            start = (start_in_calc && k == lat + 3);
            if (obs_done) seen = 1'b1;
            else begin
                check("busy_wait", obs_busy, 1);
                if (k == lat + 1) check("acc_pending", obs_acc, 0);
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("done_time", k, lat + calc);
        if (seen && res_q.size() > 0) begin
            r = res_q.pop_front();
            check("match_final", obs_match, r.match);
            check("scored_final", obs_scored, r.scored);
            check("acc_final", obs_acc, r.acc);
            check("ovf_final", obs_ovf, r.ovf);
            check("busy_in_done", obs_busy, 0);
            @(negedge clock);
            check("done_one_cycle", obs_done, 0);
            check("scored_hold", obs_scored, r.scored);
            check("acc_hold", obs_acc, r.acc);
        end
        if (use_mon) check("mism_pulses", mism_pulses, exp_scored - exp_match);
        mon_en = 1'b0;
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        exp_vec8 = 8'h00; corrupt = 1'b0; sel = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_busy", obs_busy, 0);
            check("rst_done", obs_done, 0);
            check("rst_match", obs_match, 0);
            check("rst_scored", obs_scored, 0);
            check("rst_acc", obs_acc, 0);
            check("rst_mism", obs_mism, 0);
            check("rst_ovf", obs_ovf, 0);
        end
        @(negedge clock);

        do_run(0, 15, 32'h0, 0, 0, 0, 15, 15, 100, 0, 1);
        do_run(0, 15, 32'h444, 0, 0, 0, 12, 15, 80, 0, 1);
        do_run(1, 7, 32'h7C, 0, 0, 0, 2, 7, 28, 0, 1);
        do_run(0, 1, 32'h1, 0, 1, 0, 0, 1, 0, 0, 1);
        do_run(0, 3, 32'h3, 0, 0, 0, 1, 3, 33, 0, 1);
`ifdef SNN_SB_SKIP_ZERO_EN
        do_run(0, 3, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
`else
        do_run(0, 3, 32'h0, 1, 0, 0, 3, 3, 100, 0, 1);
`endif
        do_run(2, 20, 32'h0, 0, 0, 0, 15, 15, 100, 1, 0);

        // Reset while draining: everything clears, no done follows.
        sel = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_vec8 = 8'(i + 1); exp_valid = 1'b1; exp_last = (i == 3); corrupt = (i == 1);
            @(negedge clock);
        end
        exp_valid = 1'b0; exp_last = 1'b0;
        check("busy_drain", obs_busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", obs_busy, 0);
        check("abort_done", obs_done, 0);
        check("abort_match", obs_match, 0);
        check("abort_scored", obs_scored, 0);
        check("abort_acc", obs_acc, 0);
        check("abort_mism", obs_mism, 0);
        check("abort_ovf", obs_ovf, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (obs_done || obs_busy) done_cnt++;
        end
        check("abort_quiet", done_cnt, 0);

        // start during CALC is ignored; the run finishes normally.
        do_run(0, 5, 32'h4, 0, 0, 1, 4, 5, 80, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
